word_stream_collector: RTL and testbench
========================================

Name: word_stream_collector

Overview:
- Consumer end of the request-paced word stream that our buffering repeaters emit: data word plus valid from the producer, "consumed / send next" pulse back to the producer.
- Issues exactly one request pulse per word and collects one BITS_IN_NUM-bit number as BITS_IN_NUM/REGISTER_SIZE words into internal storage.
- Holds the number and exposes a 1-cycle-latency random-access read port for downstream arithmetic (encryptor/tally) until released.

Parameters:
- BITS_IN_NUM, 4096, bits in one number.
- REGISTER_SIZE, 32, word width; BITS_IN_NUM must be an exact multiple.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with WORD_COLLECTOR_TIMEOUT_EN.
- Derived: NUM_WORDS = BITS_IN_NUM/REGISTER_SIZE; ADDR_SIZE = $clog2(NUM_WORDS).

Ports:
- clk_in  input  1  single clock.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  arm collection of one number; sampled only in IDLE.
- data_in  input  REGISTER_SIZE  word from producer.
- data_valid_in  input  1  data_in valid this cycle.
- data_consumed_out  output  1  1-cycle pulse: producer may send next word.
- number_ready_out  output  1  full number stored and readable.
- read_addr_in  input  ADDR_SIZE  word index to read, 0 = least-significant word.
- read_data_out  output  REGISTER_SIZE  registered storage[read_addr_in].
- release_in  input  1  downstream done with number; sampled only in HOLD.
- busy_out  output  1  high in any state except IDLE.
- word_count_out  output  ADDR_SIZE+1  words received so far this number.
- timeout_out  output  1  only with WORD_COLLECTOR_TIMEOUT_EN.

Behaviour:
- Reset, and every output at reset: state IDLE; count 0; data_consumed_out 0; number_ready_out 0; busy_out 0; read_data_out 0; timeout_out 0.
- rst_in mid-collection or in HOLD aborts to IDLE the next cycle. Storage contents are not cleared.
- States: IDLE, REQUEST, WAIT_WORD, HOLD.
- IDLE:
  - start_in=1 -> REQUEST; count cleared to 0.
  - data_valid_in is ignored and the word is dropped.
- REQUEST:
  - data_consumed_out=1 for exactly this cycle.
  - Next state is WAIT_WORD.
- WAIT_WORD:
  - On data_valid_in=1, write data_in to storage[count] and increment count.
  - If the new count < NUM_WORDS -> REQUEST. Otherwise -> HOLD.
- Timing:
  - start_in at cycle t -> data_consumed_out at t+1.
  - Word accepted at t -> next data_consumed_out at t+1.
  - Last word accepted at t -> number_ready_out=1 from t+1.
- Pulse count: exactly NUM_WORDS request pulses per number, the first before any word and none after the last word. This matches the repeater, which needs one pulse per emitted word and ends on the final one.
- Words on consecutive valid cycles are legal only as one per request.
  - A data_valid_in in REQUEST is treated as the awaited word: written at storage[count], count incremented, request pulse still issued.
  - A data_valid_in in HOLD is dropped.
- HOLD:
  - number_ready_out=1; no requests issued.
  - release_in=1 -> IDLE next cycle; number_ready_out falls that cycle.
  - start_in in the release cycle is ignored; start_in is sampled only once in IDLE.
- start_in outside IDLE: ignored. release_in outside HOLD: ignored.
- Read port:
  - read_data_out <= storage[read_addr_in] every cycle in every state, 1-cycle latency.
  - A read of an address being written in the same cycle returns the old contents (read-first).
  - read_addr_in >= NUM_WORDS returns 0.
- word_count_out wraps nowhere; maximum value NUM_WORDS. It holds its value in HOLD and clears on start.
- Storage: NUM_WORDS x REGISTER_SIZE single-clock RAM (inferred BRAM), one write port and one read port.

Optional Feature:
- Macro: WORD_COLLECTOR_TIMEOUT_EN.
- With the macro:
  - A counter clears on every request pulse and increments each WAIT_WORD cycle without data_valid_in.
  - On reaching TIMEOUT_CYCLES: timeout_out=1 (sticky), state -> IDLE, count kept for debug.
  - timeout_out clears on the next accepted start_in or on rst_in.
- Without the macro: the timeout_out port and counter are absent; WAIT_WORD waits indefinitely.

Test Plan:
- BITS_IN_NUM=128, REGISTER_SIZE=32. Pulse start_in, answer each request 2 cycles later with words 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> exactly 4 consumed pulses; number_ready_out 1 cycle after the 4th word; reads at addr 0..3 return the words in order with 1-cycle latency.
- Producer answers in the same cycle as each request (valid during REQUEST) -> all 4 words stored, 4 pulses total, no duplicates.
- Spurious data_valid_in with 0xDEADBEEF in IDLE and in HOLD -> ignored; storage unchanged; no pulse.
- rst_in asserted after 2 of 4 words -> next cycle IDLE, busy_out 0, word_count_out 0. Restart collects 4 fresh words correctly.
- In HOLD: release_in together with start_in -> IDLE, start ignored. start_in on the following cycle -> pulse one cycle later.
- With WORD_COLLECTOR_TIMEOUT_EN, TIMEOUT_CYCLES=8: withhold the 2nd word -> timeout_out=1 exactly 8 WAIT_WORD cycles after the 2nd request; state IDLE; word_count_out=1.

Source files
------------

// File: rtl/word_stream_collector.sv
`default_nettype none
// ============================================================================
// Module      : word_stream_collector
// Description : Consumer end of a request-paced word stream. Issues one
//               request pulse per word, assembles one BITS_IN_NUM-bit number
//               from BITS_IN_NUM/REGISTER_SIZE words in an inferred RAM and
//               holds it behind a 1-cycle-latency random-access read port
//               until downstream logic releases it.
//               Optional macro WORD_COLLECTOR_TIMEOUT_EN adds a watchdog
//               that abandons a stalled collection after TIMEOUT_CYCLES
//               idle waiting cycles and raises a sticky timeout_out flag.
// Revision    : 1.0 - initial release
// ============================================================================
module word_stream_collector #(
    parameter int  BITS_IN_NUM    = 4096,
    parameter int  REGISTER_SIZE  = 32,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int NUM_WORDS      = BITS_IN_NUM / REGISTER_SIZE,
    localparam int ADDR_SIZE      = $clog2(NUM_WORDS)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_in,
    input  logic [REGISTER_SIZE-1:0] data_in,
    input  logic                     data_valid_in,
    output logic                     data_consumed_out,
    output logic                     number_ready_out,
    input  logic [ADDR_SIZE-1:0]     read_addr_in,
    output logic [REGISTER_SIZE-1:0] read_data_out,
    input  logic                     release_in,
    output logic                     busy_out,
    output logic [ADDR_SIZE:0]       word_count_out
`ifdef WORD_COLLECTOR_TIMEOUT_EN
    ,
    output logic                     timeout_out
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = ADDR_SIZE + 1;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_REQUEST   = 2'd1;
    localparam logic [1:0] c_ST_WAIT_WORD = 2'd2;
    localparam logic [1:0] c_ST_HOLD      = 2'd3;

    // Count value at which the word being accepted is the final one
    localparam logic [c_CNT_W-1:0] c_LAST_IDX  = c_CNT_W'(NUM_WORDS - 1);
    localparam logic [c_CNT_W-1:0] c_NUM_WORDS = c_CNT_W'(NUM_WORDS);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]               r_state;
    logic [1:0]               w_state_next;
    logic [c_CNT_W-1:0]       r_count;
    logic                     w_start_accept;
    logic                     w_word_accept;
    logic                     w_last_word;
    logic                     w_wr_en;
    logic                     w_timeout_hit;
    logic [REGISTER_SIZE-1:0] r_mem [NUM_WORDS];

    // A start is only honoured from IDLE; a word is only taken while a
    // request is outstanding (REQUEST or WAIT_WORD).
    assign w_start_accept = (r_state == c_ST_IDLE) && start_in;
    assign w_word_accept  = data_valid_in &&
                            ((r_state == c_ST_REQUEST) || (r_state == c_ST_WAIT_WORD));
    assign w_last_word    = (r_count == c_LAST_IDX);

    // ------------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------------
`ifdef WORD_COLLECTOR_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout;

    // Fires on the cycle that would bring the idle-wait count to the limit
    assign w_timeout_hit = (r_state == c_ST_WAIT_WORD) && !data_valid_in &&
                           (r_to_cnt == c_TO_LAST);

    // Idle-wait counter: cleared by every request pulse, advanced by each
    // WAIT_WORD cycle in which the producer stays silent.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_to_cnt <= '0;
        end else if (r_state == c_ST_REQUEST) begin
            r_to_cnt <= '0;
        end else if ((r_state == c_ST_WAIT_WORD) && !data_valid_in) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, cleared only by a fresh accepted start or reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_timeout <= 1'b0;
        end else if (w_start_accept) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout_out = r_timeout;
`else
    logic w_unused_timeout_cfg;

    // Without the watchdog a stalled producer is waited on indefinitely;
    // the limit parameter is kept referenced so every build elaborates alike.
    assign w_timeout_hit        = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a word seen in REQUEST counts as the awaited word so
    // a producer answering in the same cycle is paced one word per pulse.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start_in) begin
                    w_state_next = c_ST_REQUEST;
                end
            end
            c_ST_REQUEST: begin
                if (data_valid_in) begin
                    w_state_next = w_last_word ? c_ST_HOLD : c_ST_REQUEST;
                end else begin
                    w_state_next = c_ST_WAIT_WORD;
                end
            end
            c_ST_WAIT_WORD: begin
                if (data_valid_in) begin
                    w_state_next = w_last_word ? c_ST_HOLD : c_ST_REQUEST;
                end else if (w_timeout_hit) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_HOLD: begin
                if (release_in) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Moore outputs plus the storage write strobe
    always_comb begin
        data_consumed_out = (r_state == c_ST_REQUEST);
        number_ready_out  = (r_state == c_ST_HOLD);
        busy_out          = (r_state != c_ST_IDLE);
        w_wr_en           = w_word_accept && !rst_in;
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------

    // Word counter: cleared by an accepted start, advanced per stored word,
    // left untouched in HOLD and after a watchdog abort for debug visibility.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_count <= '0;
        end else if (w_start_accept) begin
            r_count <= '0;
        end else if (w_wr_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign word_count_out = r_count;

    // Storage write port; contents deliberately survive reset
    always_ff @(posedge clk_in) begin
        if (w_wr_en) begin
            r_mem[r_count[ADDR_SIZE-1:0]] <= data_in;
        end
    end

    // Registered read port, read-first against a same-cycle write
    generate
        if ((1 << ADDR_SIZE) == NUM_WORDS) begin : g_rd_pow2
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    read_data_out <= '0;
                end else begin
                    read_data_out <= r_mem[read_addr_in];
                end
            end
        end else begin : g_rd_bounded
            // Addresses past the last word read back as zero
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    read_data_out <= '0;
                end else if ({1'b0, read_addr_in} < c_NUM_WORDS) begin
                    read_data_out <= r_mem[read_addr_in];
                end else begin
                    read_data_out <= '0;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_word_stream_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_word_stream_collector
// Description : Self-checking bench for word_stream_collector configured as
//               4 x 32-bit words. Table-driven cycle vectors plus hand-built
//               producer sequences; readback goes through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_word_stream_collector;

    localparam int BITS = 128;
    localparam int RS   = 32;
    localparam int NW   = 4;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic [31:0] data_in;
    logic        data_valid_in;
    logic        data_consumed_out;
    logic        number_ready_out;
    logic [1:0]  read_addr_in;
    logic [31:0] read_data_out;
    logic        release_in;
    logic        busy_out;
    logic [2:0]  word_count_out;
`ifdef WORD_COLLECTOR_TIMEOUT_EN
    logic        timeout_out;
`endif

    word_stream_collector #(
        .BITS_IN_NUM    (BITS),
        .REGISTER_SIZE  (RS),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .start_in          (start_in),
        .data_in           (data_in),
        .data_valid_in     (data_valid_in),
        .data_consumed_out (data_consumed_out),
        .number_ready_out  (number_ready_out),
        .read_addr_in      (read_addr_in),
        .read_data_out     (read_data_out),
        .release_in        (release_in),
        .busy_out          (busy_out),
        .word_count_out    (word_count_out)
`ifdef WORD_COLLECTOR_TIMEOUT_EN
        ,
        .timeout_out       (timeout_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int pulse_total = 0;

    logic [31:0] ref_mem  [NW];
    logic [31:0] wr_words [NW];
    logic [31:0] sb_q [$];

    typedef struct {
        logic        start;
        logic        rel;
        logic        valid;
        logic [31:0] data;
        logic        exp_cons;
        logic        exp_ready;
        logic        exp_busy;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t tbl [12];

    // Request pulses counted on the falling edge
    always @(negedge clk_in) begin
        if (data_consumed_out === 1'b1) pulse_total++;
    end

    // Hard time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bench producer: waits for each request, answers lat cycles later
    task automatic produce(input int lat, input int n);
        int guard;
        for (int w = 0; w < n; w++) begin
            guard = 0;
            while (data_consumed_out !== 1'b1 && guard < 50) begin
                tick();
                guard++;
            end
            if (data_consumed_out !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL request_wait: got no request for word %0d expected a pulse", w);
                return;
            end
            repeat (lat) tick();
            check("ready_early", number_ready_out, 1'b0);
            data_valid_in = 1'b1;
            data_in       = wr_words[w];
            ref_mem[w]    = wr_words[w];
            tick();
            data_valid_in = 1'b0;
            data_in       = '0;
        end
    endtask

    // Scoreboard readback: expectation queued at address drive, popped on output
    task automatic readback();
        logic [31:0] exp;
        for (int a = 0; a < NW; a++) begin
            read_addr_in = 2'(a);
            sb_q.push_back(ref_mem[a]);
            tick();
            exp = sb_q.pop_front();
            check($sformatf("read_addr%0d", a), read_data_out, exp);
        end
    endtask

    initial begin
        int base;

        tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 3'd4};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 3'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'hA0A0A0A0, 1'b1, 1'b0, 1'b1, 3'd1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'hB1B1B1B1, 1'b1, 1'b0, 1'b1, 3'd2};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'hC2C2C2C2, 1'b1, 1'b0, 1'b1, 3'd3};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'hD3D3D3D3, 1'b0, 1'b1, 1'b1, 3'd4};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 3'd4};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 3'd4};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd4};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 3'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 3'd0};

        rst_in        = 1'b1;
        start_in      = 1'b0;
        data_in       = '0;
        data_valid_in = 1'b0;
        read_addr_in  = '0;
        release_in    = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_consumed", data_consumed_out, 1'b0);
        check("rst_ready", number_ready_out, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_rdata", read_data_out, 32'h0);
        check("rst_count", word_count_out, 3'd0);
`ifdef WORD_COLLECTOR_TIMEOUT_EN
        check("rst_timeout", timeout_out, 1'b0);
`endif
        rst_in = 1'b0;
        tick();

        // ---------------- producer answers 2 cycles after each request ----------------
        wr_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        base = pulse_total;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("start_to_pulse", data_consumed_out, 1'b1);
        check("busy_req", busy_out, 1'b1);
        produce(2, 4);
        check("ready_after_last", number_ready_out, 1'b1);
        check("count_full", word_count_out, 3'd4);
        repeat (3) tick();
        check("pulses_lat2", 32'(pulse_total - base), 32'd4);
        check("ready_held", number_ready_out, 1'b1);
        readback();
        release_in = 1'b1;
        tick();
        release_in = 1'b0;
        check("release_ready", number_ready_out, 1'b0);
        check("release_busy", busy_out, 1'b0);

        // ---------------- table: spurious data, same-cycle answers, release+start ----------------
        read_addr_in = 2'd0;
        for (int i = 0; i < 12; i++) begin
            start_in      = tbl[i].start;
            release_in    = tbl[i].rel;
            data_valid_in = tbl[i].valid;
            data_in       = tbl[i].data;
            tick();
            check($sformatf("tbl%0d_consumed", i), data_consumed_out, tbl[i].exp_cons);
            check($sformatf("tbl%0d_ready", i), number_ready_out, tbl[i].exp_ready);
            check($sformatf("tbl%0d_busy", i), busy_out, tbl[i].exp_busy);
            check($sformatf("tbl%0d_count", i), word_count_out, tbl[i].exp_cnt);
            if (i == 2) check("read_first_old", read_data_out, ref_mem[0]);
            if (i == 3) check("read_after_write", read_data_out, tbl[2].data);
        end
        start_in      = 1'b0;
        release_in    = 1'b0;
        data_valid_in = 1'b0;
        data_in       = '0;
        for (int a = 0; a < NW; a++) ref_mem[a] = tbl[a + 2].data;
        readback();

        // ---------------- reset mid-collection ----------------
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        wr_words = '{32'h55555555, 32'h66666666, 32'h0, 32'h0};
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        produce(1, 2);
        check("mid_count2", word_count_out, 3'd2);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("abort_busy", busy_out, 1'b0);
        check("abort_count", word_count_out, 3'd0);
        check("abort_consumed", data_consumed_out, 1'b0);
        check("abort_ready", number_ready_out, 1'b0);
        readback();

        wr_words = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
        base = pulse_total;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        produce(1, 4);
        check("restart_ready", number_ready_out, 1'b1);
        repeat (2) tick();
        check("restart_pulses", 32'(pulse_total - base), 32'd4);
        readback();
        release_in = 1'b1;
        tick();
        release_in = 1'b0;
        check("restart_release", busy_out, 1'b0);

`ifdef WORD_COLLECTOR_TIMEOUT_EN
        // ---------------- watchdog: withhold the second word ----------------
        wr_words = '{32'h77777777, 32'h0, 32'h0, 32'h0};
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        produce(1, 1);
        check("to_second_req", data_consumed_out, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("to_wait%0d", k), timeout_out, 1'b0);
        end
        tick();
        check("to_fired", timeout_out, 1'b1);
        check("to_idle", busy_out, 1'b0);
        check("to_count_kept", word_count_out, 3'd1);
        repeat (2) tick();
        check("to_sticky", timeout_out, 1'b1);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("to_cleared", timeout_out, 1'b0);
        check("to_restart_pulse", data_consumed_out, 1'b1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
